// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared constants and types for the fetch stage
package riscv_pkg;

  localparam logic [31:0] NOP_INST          = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_HALT_INST = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    FULL = 2'd2,
    HALT = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - instruction fetch stage feeding the IF/ID register
// Single outstanding request; redirects drop in-flight responses; stops on the halt word.
module if_fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] HALT_INST = DEFAULT_HALT_INST
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic [31:0] redirect_pc,
  input  logic        hazard,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        if_valid,
  output logic        halted
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         drop_q, drop_d;
  logic [31:0]  inst_q, inst_d;
  logic [31:0]  redirect_aligned;

  assign redirect_aligned = redirect_pc & ~32'h0000_0003;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= REQ;
      pc_q    <= RESET_PC;
      drop_q  <= 1'b0;
      inst_q  <= NOP_INST;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      drop_q  <= drop_d;
      inst_q  <= inst_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    drop_d  = drop_q;
    inst_d  = inst_q;
    unique case (state_q)
      REQ: begin
        if (flush) begin
          pc_d = redirect_aligned;
        end else if (imem_ready) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        // A redirect with no response yet leaves one stale reply in flight to discard.
        if (flush) begin
          pc_d = redirect_aligned;
          if (imem_rvalid) begin
            state_d = REQ;
            drop_d  = 1'b0;
          end else begin
            drop_d  = 1'b1;
          end
        end else if (imem_rvalid) begin
          if (drop_q) begin
            drop_d  = 1'b0;
            state_d = REQ;
          end else begin
            inst_d  = imem_rdata;
            state_d = FULL;
          end
        end
      end
      FULL: begin
        if (flush) begin
          pc_d    = redirect_aligned;
          state_d = REQ;
        end else if (!hazard) begin
          if (inst_q == HALT_INST) begin
            state_d = HALT;
          end else begin
            pc_d    = pc_q + 32'd4;
            state_d = REQ;
          end
        end
      end
      HALT: begin
        if (flush) begin
          pc_d    = redirect_aligned;
          state_d = REQ;
        end
      end
      default: state_d = REQ;
    endcase
  end

  always_comb begin
    imem_req  = (state_q == REQ) && !flush && !rst;
    imem_addr = pc_q;
    if_pc     = rst ? RESET_PC : pc_q;
    if_valid  = (state_q == FULL) && !rst;
    if_inst   = if_valid ? inst_q : NOP_INST;
    halted    = (state_q == HALT) && !rst;
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb/tb_if_fetch_unit.sv - directed vector table plus randomized run against a reference model
module tb_if_fetch_unit;

  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [31:0] HALTW = 32'hFFFF_FFFF;

  logic        clk;
  logic        rst;
  logic        flush;
  logic [31:0] redirect_pc;
  logic        hazard;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_valid;
  logic        halted;

  if_fetch_unit dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .redirect_pc (redirect_pc),
    .hazard      (hazard),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .if_pc       (if_pc),
    .if_inst     (if_inst),
    .if_valid    (if_valid),
    .halted      (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        flush;
    logic [31:0] rpc;
    logic        hazard;
    logic        ready;
    logic        rvalid;
    logic [31:0] rdata;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_inst;
    logic        e_halted;
  } vec_t;

  typedef struct {
    int          due;
    logic [31:0] data;
  } resp_t;

  vec_t  vecs[$];
  resp_t mq[$];
  int    n_checks = 0;
  int    n_fail   = 0;

  // Reference model state: what the fetch stage has promised, not how it is encoded.
  logic [31:0] m_pc;
  logic        m_busy, m_stale, m_have, m_halt;
  logic [31:0] m_inst;

  function automatic logic [31:0] dat(input logic [31:0] a);
    return a ^ 32'h5A00_0000;
  endfunction

  task automatic add(input logic r, input logic f, input logic [31:0] rp, input logic h,
                     input logic rdy, input logic rv, input logic [31:0] rd,
                     input logic e_req, input logic [31:0] e_addr, input logic e_v,
                     input logic [31:0] e_pc, input logic [31:0] e_inst, input logic e_h);
    vec_t v;
    v = '{r, f, rp, h, rdy, rv, rd, e_req, e_addr, e_v, e_pc, e_inst, e_h};
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %h, expected %h", name, idx, act, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input int idx, input logic e_req,
                               input logic [31:0] e_addr, input logic e_v,
                               input logic [31:0] e_pc, input logic [31:0] e_inst,
                               input logic e_h);
    check({tag, ".imem_req"},  idx, {31'd0, imem_req}, {31'd0, e_req});
    check({tag, ".imem_addr"}, idx, imem_addr, e_addr);
    check({tag, ".if_valid"},  idx, {31'd0, if_valid}, {31'd0, e_v});
    check({tag, ".if_pc"},     idx, if_pc, e_pc);
    check({tag, ".if_inst"},   idx, if_inst, e_inst);
    check({tag, ".halted"},    idx, {31'd0, halted}, {31'd0, e_h});
  endtask

  task automatic model_step(input logic r, input logic f, input logic [31:0] rp,
                            input logic h, input logic rdy, input logic rv,
                            input logic [31:0] rd);
    if (r) begin
      m_pc = 32'h0; m_busy = 0; m_stale = 0; m_have = 0; m_halt = 0; m_inst = NOP;
    end else if (f) begin
      m_pc = {rp[31:2], 2'b00};
      m_have = 0;
      m_halt = 0;
      if (m_busy && !rv) m_stale = 1;
      else begin m_busy = 0; m_stale = 0; end
    end else if (m_busy) begin
      if (rv) begin
        if (!m_stale) begin m_have = 1; m_inst = rd; end
        m_busy = 0;
        m_stale = 0;
      end
    end else if (m_have) begin
      if (!h) begin
        m_have = 0;
        if (m_inst == HALTW) m_halt = 1;
        else m_pc = m_pc + 32'd4;
      end
    end else if (!m_halt && rdy) begin
      m_busy = 1;
    end
  endtask

  initial begin
    rst = 1; flush = 0; redirect_pc = 0; hazard = 0;
    imem_ready = 0; imem_rvalid = 0; imem_rdata = 0;

    add(1,0,32'h0,0,0,0,32'h0,           0,32'h0,0,32'h0,NOP,0);
    add(0,0,32'h0,0,1,0,32'h0,           1,32'h0,0,32'h0,NOP,0);
    add(0,0,32'h0,0,0,1,dat(32'h0),      0,32'h0,0,32'h0,NOP,0);
    add(0,0,32'h0,0,0,0,32'h0,           0,32'h0,1,32'h0,dat(32'h0),0);
    add(0,0,32'h0,0,1,0,32'h0,           1,32'h4,0,32'h4,NOP,0);
    add(0,0,32'h0,0,0,1,dat(32'h4),      0,32'h4,0,32'h4,NOP,0);
    add(0,0,32'h0,0,0,0,32'h0,           0,32'h4,1,32'h4,dat(32'h4),0);
    add(0,0,32'h0,0,1,0,32'h0,           1,32'h8,0,32'h8,NOP,0);
    add(0,0,32'h0,0,0,1,dat(32'h8),      0,32'h8,0,32'h8,NOP,0);
    for (int i = 0; i < 4; i++)
      add(0,0,32'h0,1,1,0,32'h0,         0,32'h8,1,32'h8,dat(32'h8),0);
    add(0,0,32'h0,0,1,0,32'h0,           0,32'h8,1,32'h8,dat(32'h8),0);
    add(0,0,32'h0,0,1,0,32'h0,           1,32'hC,0,32'hC,NOP,0);
    add(0,0,32'h0,0,0,1,dat(32'hC),      0,32'hC,0,32'hC,NOP,0);
    add(0,0,32'h0,0,0,0,32'h0,           0,32'hC,1,32'hC,dat(32'hC),0);
    add(0,0,32'h0,0,1,0,32'h0,           1,32'h10,0,32'h10,NOP,0);
    add(0,1,32'h100,0,1,0,32'h0,         0,32'h10,0,32'h10,NOP,0);
    add(0,0,32'h0,0,1,0,32'h0,           0,32'h100,0,32'h100,NOP,0);
    add(0,0,32'h0,0,1,1,dat(32'h10),     0,32'h100,0,32'h100,NOP,0);
    add(0,0,32'h0,0,1,0,32'h0,           1,32'h100,0,32'h100,NOP,0);
    add(0,0,32'h0,0,0,1,dat(32'h100),    0,32'h100,0,32'h100,NOP,0);
    add(0,0,32'h0,0,0,0,32'h0,           0,32'h100,1,32'h100,dat(32'h100),0);
    add(0,0,32'h0,0,1,0,32'h0,           1,32'h104,0,32'h104,NOP,0);
    add(0,1,32'h203,1,0,1,dat(32'h104),  0,32'h104,0,32'h104,NOP,0);
    add(0,0,32'h0,0,0,0,32'h0,           1,32'h200,0,32'h200,NOP,0);
    add(0,0,32'h0,0,1,0,32'h0,           1,32'h200,0,32'h200,NOP,0);
    add(0,0,32'h0,0,0,1,dat(32'h200),    0,32'h200,0,32'h200,NOP,0);
    add(0,0,32'h0,0,0,0,32'h0,           0,32'h200,1,32'h200,dat(32'h200),0);
    add(0,1,32'h14,0,1,0,32'h0,          0,32'h204,0,32'h204,NOP,0);
    add(0,0,32'h0,0,1,0,32'h0,           1,32'h14,0,32'h14,NOP,0);
    add(0,0,32'h0,0,0,1,HALTW,           0,32'h14,0,32'h14,NOP,0);
    add(0,0,32'h0,0,0,0,32'h0,           0,32'h14,1,32'h14,HALTW,0);
    add(0,0,32'h0,0,1,0,32'h0,           0,32'h14,0,32'h14,NOP,1);
    add(0,0,32'h0,0,1,0,32'h0,           0,32'h14,0,32'h14,NOP,1);
    add(0,1,32'h40,0,1,0,32'h0,          0,32'h14,0,32'h14,NOP,1);
    add(0,0,32'h0,0,1,0,32'h0,           1,32'h40,0,32'h40,NOP,0);
    add(0,0,32'h0,0,0,1,dat(32'h40),     0,32'h40,0,32'h40,NOP,0);
    add(0,0,32'h0,0,0,0,32'h0,           0,32'h40,1,32'h40,dat(32'h40),0);
    add(0,1,32'hFFFF_FFFC,0,1,0,32'h0,   0,32'h44,0,32'h44,NOP,0);
    add(0,0,32'h0,0,1,0,32'h0,           1,32'hFFFF_FFFC,0,32'hFFFF_FFFC,NOP,0);
    add(0,0,32'h0,0,0,1,dat(32'hFFFF_FFFC), 0,32'hFFFF_FFFC,0,32'hFFFF_FFFC,NOP,0);
    add(0,0,32'h0,0,0,0,32'h0,           0,32'hFFFF_FFFC,1,32'hFFFF_FFFC,dat(32'hFFFF_FFFC),0);
    add(0,0,32'h0,0,1,0,32'h0,           1,32'h0,0,32'h0,NOP,0);
    add(0,0,32'h0,0,0,1,dat(32'h0),      0,32'h0,0,32'h0,NOP,0);
    add(0,0,32'h0,0,0,0,32'h0,           0,32'h0,1,32'h0,dat(32'h0),0);
    add(0,0,32'h0,0,1,0,32'h0,           1,32'h4,0,32'h4,NOP,0);
    add(1,0,32'h0,0,1,0,32'h0,           0,32'h4,0,32'h0,NOP,0);
    add(0,0,32'h0,0,0,1,dat(32'h4),      1,32'h0,0,32'h0,NOP,0);
    add(0,0,32'h0,0,1,0,32'h0,           1,32'h0,0,32'h0,NOP,0);
    add(0,0,32'h0,0,0,1,dat(32'h0),      0,32'h0,0,32'h0,NOP,0);
    add(0,0,32'h0,0,0,0,32'h0,           0,32'h0,1,32'h0,dat(32'h0),0);

    repeat (2) @(negedge clk);

    foreach (vecs[i]) begin
      @(negedge clk);
      rst = vecs[i].rst; flush = vecs[i].flush; redirect_pc = vecs[i].rpc;
      hazard = vecs[i].hazard; imem_ready = vecs[i].ready;
      imem_rvalid = vecs[i].rvalid; imem_rdata = vecs[i].rdata;
      #1;
      check_outputs("vec", i, vecs[i].e_req, vecs[i].e_addr, vecs[i].e_valid,
                    vecs[i].e_pc, vecs[i].e_inst, vecs[i].e_halted);
    end

    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic        e_req, e_v, e_h;
      logic [31:0] e_pc, e_inst;
      @(negedge clk);
      rst         = (cyc == 0) || ($urandom_range(0, 149) == 0);
      flush       = ($urandom_range(0, 9) == 0);
      redirect_pc = $urandom;
      hazard      = ($urandom_range(0, 2) == 0);
      imem_ready  = ($urandom_range(0, 9) < 7);
      if (mq.size() > 0 && mq[0].due <= cyc) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mq[0].data;
        void'(mq.pop_front());
      end else if ($urandom_range(0, 19) == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = $urandom;
      end else begin
        imem_rvalid = 1'b0;
        imem_rdata  = $urandom;
      end
      #1;
      e_req  = !rst && !flush && !m_busy && !m_have && !m_halt;
      e_v    = !rst && m_have;
      e_h    = !rst && m_halt;
      e_pc   = rst ? 32'h0 : m_pc;
      e_inst = e_v ? m_inst : NOP;
      if (cyc > 0)
        check_outputs("rnd", cyc, e_req, m_pc, e_v, e_pc, e_inst, e_h);
      if (imem_req && imem_ready)
        mq.push_back('{cyc + int'($urandom_range(1, 3)),
                       ($urandom_range(0, 15) == 0) ? HALTW : dat(imem_addr)});
      model_step(rst, flush, redirect_pc, hazard, imem_ready, imem_rvalid, imem_rdata);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
# if_fetch_unit

Instruction-fetch stage that produces the PC/instruction pair captured by the IF/ID pipeline register. It owns the fetch PC, issues single-outstanding requests to instruction memory, and holds the fetched word while the pipeline stalls. It drops in-flight responses on a redirect and stops fetching after the halt word 0xFFFFFFFF is consumed. It consumes the same `flush` and `hazard` (stall) controls that drive IF/ID.

## Interface
- `RESET_PC`, 32'h0000_0000: fetch address after reset.
- `HALT_INST`, 32'hFFFF_FFFF: instruction word that ends fetching.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `flush` in 1: redirect request; wins over `hazard`.
- `redirect_pc` in 32: new fetch PC, sampled when `flush`=1; bits [1:0] ignored and forced to 0.
- `hazard` in 1: stall; hold the presented instruction.
- `imem_req` out 1: request valid.
- `imem_addr` out 32: request word address, equal to the fetch PC.
- `imem_ready` in 1: memory accepts the request this cycle.
- `imem_rvalid` in 1: response valid, earliest one cycle after acceptance.
- `imem_rdata` in 32: response instruction.
- `if_pc` out 32: PC of the presented instruction.
- `if_inst` out 32: presented instruction; NOP 32'h0000_0013 when not valid.
- `if_valid` out 1: a real instruction is presented.
- `halted` out 1: fetch stopped on `HALT_INST`.

## Operation
- State register `state` takes REQ, WAIT, FULL or HALT. Other registers are `pc` [31:0], `drop` (1 bit) and `inst_q` [31:0].
- Reset: state REQ, `pc`=`RESET_PC`, `drop`=0, `inst_q`=NOP. While `rst`=1: `imem_req`=0, `if_valid`=0, `if_inst`=NOP, `if_pc`=`RESET_PC`, `halted`=0.
- `imem_req` = (state==REQ) && !flush && !rst. `imem_addr` = `pc`. `if_pc` = `pc`. `if_valid` = (state==FULL). `if_inst` = `if_valid` ? `inst_q` : NOP. `halted` = (state==HALT).
- State REQ:
  - If `flush`=1: `pc`←`redirect_pc`, stay in REQ. No request is issued in a flush cycle.
  - Else if `imem_ready`=1: go to WAIT.
- State WAIT:
  - If `flush`=1: `pc`←`redirect_pc`. If `imem_rvalid`=1 in the same cycle, go to REQ with `drop`←0. Otherwise set `drop`←1 and stay in WAIT.
  - Else if `imem_rvalid`=1 and `drop`=1: `drop`←0, go to REQ.
  - Else if `imem_rvalid`=1 and `drop`=0: `inst_q`←`imem_rdata`, go to FULL.
- State FULL:
  - If `flush`=1: `pc`←`redirect_pc`, go to REQ.
  - Else if `hazard`=1: hold everything.
  - Else the instruction is consumed. If `inst_q`==`HALT_INST`, go to HALT with `pc` unchanged. Otherwise `pc`←`pc`+4 and go to REQ.
- State HALT:
  - No requests are issued.
  - `flush`=1 → `pc`←`redirect_pc`, go to REQ, and `halted` deasserts. This covers a halt word fetched down a wrong path.
- PC arithmetic is modulo 2^32: 32'hFFFF_FFFC+4 = 32'h0000_0000.
- `imem_rvalid` is ignored outside WAIT. This includes stale responses after a mid-transaction `rst`, which returns to REQ at `RESET_PC` with `drop`=0.

## Timing
- Zero-wait memory (ready=1, rvalid one cycle later):
  - Request accepted in cycle n.
  - Response in n+1.
  - `if_valid`=1 in n+2.
  - If unstalled, next request in n+3.
- Sustained rate is one instruction per 3 cycles.
- Each memory wait cycle adds one cycle.
- Each `hazard` cycle in FULL adds one cycle. `if_pc` and `if_inst` are stable throughout the stall.
- After `flush` in any state, the first request to `redirect_pc` comes on the next cycle, or after the dropped response returns.
- `halted` rises the cycle after the halt word is consumed.

## Structure
- Shared package `riscv_pkg` holds:
  - `NOP_INST` = 32'h0000_0013.
  - Default `HALT_INST`.
  - Typedef `fetch_state_t` with REQ, WAIT, FULL, HALT.
- Single module, no sub-module. PC increment and redirect mux are inline.

## Test plan
- Reset then zero-wait memory returning addr-dependent data: requests at 0x0, 0x4, 0x8, spaced 3 cycles apart. `if_pc`/`if_inst` match each address. `if_valid` pulses for 1 cycle each.
- `hazard`=1 for 4 cycles while FULL at PC 0x8: `if_pc`=0x8 and `if_inst` held. No `imem_req` during the stall. Request to 0xC one cycle after `hazard` drops.
- `flush` with `redirect_pc`=0x100 while in WAIT for 0x10, response 2 cycles later: response never appears on `if_inst`. Next request goes to 0x100.
- `flush`, `imem_rvalid` and `hazard` in the same cycle in WAIT with `redirect_pc`=0x203: response dropped. Next cycle `imem_req`=1 with `imem_addr`=0x200.
- Memory returns 0xFFFFFFFF at 0x14: `if_valid` with that word, then `halted`=1 and no further requests. `flush` to 0x40 clears `halted` and fetch resumes at 0x40.
- `flush` to 0xFFFFFFFC, then consume: next request address is 0x0. Assert `rst` mid-WAIT with a late `imem_rvalid`: it is ignored and the next request goes to `RESET_PC`.
